// File: rtl/perf_memsys_collector.sv
// perf_memsys_collector: per-channel memory-system event counters with wrap or
// saturate mode, sticky overflow, an atomic snapshot bank and a 1-deep read port.

module perf_memsys_chan #(
   parameter int CTR_BITS = 44,
   parameter int INC_BITS = 4,
   parameter int SATURATE = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic                snap,
   input  logic [INC_BITS-1:0] inc,
   output logic [CTR_BITS-1:0] snap_val,
   output logic                ovf
);
   logic [CTR_BITS-1:0] live;
   logic [CTR_BITS:0]   sum;

   assign sum = {1'b0, live} + (CTR_BITS+1)'(inc);

   // Snapshot samples live before this cycle's clear/increment takes effect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         live     <= '0;
         ovf      <= 1'b0;
         snap_val <= '0;
      end else begin
         if (snap) snap_val <= live;
         if (clear) begin
            live <= '0;
            ovf  <= 1'b0;
         end else if (enable) begin
            if (sum[CTR_BITS]) begin
               ovf  <= 1'b1;
               live <= (SATURATE != 0) ? {CTR_BITS{1'b1}} : sum[CTR_BITS-1:0];
            end else begin
               live <= sum[CTR_BITS-1:0];
            end
         end
      end
   end
endmodule

module perf_memsys_collector #(
   parameter int NUM_CHANNELS = 26,
   parameter int CTR_BITS     = 44,
   parameter int INC_BITS     = 4,
   parameter int SATURATE     = 0,
   parameter int ADDR_BITS    = $clog2(NUM_CHANNELS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             enable,
   input  logic [NUM_CHANNELS*INC_BITS-1:0] evt_inc,
   input  logic                             clear,
   input  logic                             snap,
   input  logic                             req_valid,
   input  logic [ADDR_BITS-1:0]             req_addr,
   output logic                             req_ready,
   output logic                             rsp_valid,
   output logic [CTR_BITS-1:0]              rsp_data,
   output logic                             rsp_err,
   input  logic                             rsp_ready,
   output logic [NUM_CHANNELS-1:0]          ovf_flags
);
   typedef struct packed {
      logic                err;
      logic [CTR_BITS-1:0] data;
   } rsp_t;

   logic [NUM_CHANNELS-1:0][CTR_BITS-1:0] snap_bank;
   rsp_t rsp_q, rsp_d;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
      perf_memsys_chan #(
         .CTR_BITS(CTR_BITS),
         .INC_BITS(INC_BITS),
         .SATURATE(SATURATE)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .enable   (enable),
         .clear    (clear),
         .snap     (snap),
         .inc      (evt_inc[i*INC_BITS +: INC_BITS]),
         .snap_val (snap_bank[i]),
         .ovf      (ovf_flags[i])
      );
   end

   // Address decode doubles as the range check: no match means out of range.
   always_comb begin
      rsp_d      = '0;
      rsp_d.err  = 1'b1;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (req_addr == ADDR_BITS'(i)) begin
            rsp_d.data = snap_bank[i];
            rsp_d.err  = 1'b0;
         end
      end
   end

   assign req_ready = !rsp_valid || rsp_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_q     <= '0;
      end else if (req_valid && req_ready) begin
         rsp_valid <= 1'b1;
         rsp_q     <= rsp_d;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

   assign rsp_data = rsp_q.data;
   assign rsp_err  = rsp_q.err;
endmodule

// File: tb/tb_perf_memsys_collector.sv
// Directed bench for perf_memsys_collector: default build plus two 8-bit
// two-channel builds (wrap and saturate) sharing one stimulus.

module tb_perf_memsys_collector;
   localparam int NCH = 26;
   localparam int CB  = 44;
   localparam int IB  = 4;
   localparam int AB  = 5;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   logic              enable = 1'b0, clear = 1'b0, snap = 1'b0;
   logic [NCH*IB-1:0] evt_inc = '0;
   logic              req_valid = 1'b0, rsp_ready = 1'b1;
   logic [AB-1:0]     req_addr = '0;
   logic              req_ready, rsp_valid, rsp_err;
   logic [CB-1:0]     rsp_data;
   logic [NCH-1:0]    ovf_flags;

   logic       s_enable = 1'b0, s_clear = 1'b0, s_snap = 1'b0;
   logic [7:0] s_inc = '0;
   logic       s_req_valid = 1'b0, s_rsp_ready = 1'b1;
   logic [0:0] s_req_addr = '0;
   logic       w_req_ready, w_rsp_valid, w_rsp_err;
   logic [7:0] w_rsp_data;
   logic [1:0] w_ovf;
   logic       t_req_ready, t_rsp_valid, t_rsp_err;
   logic [7:0] t_rsp_data;
   logic [1:0] t_ovf;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   perf_memsys_collector dut (
      .clk(clk), .reset(reset), .enable(enable), .evt_inc(evt_inc),
      .clear(clear), .snap(snap), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .rsp_ready(rsp_ready), .ovf_flags(ovf_flags)
   );

   perf_memsys_collector #(.NUM_CHANNELS(2), .CTR_BITS(8), .INC_BITS(4), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset(reset), .enable(s_enable), .evt_inc(s_inc),
      .clear(s_clear), .snap(s_snap), .req_valid(s_req_valid), .req_addr(s_req_addr),
      .req_ready(w_req_ready), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
      .rsp_err(w_rsp_err), .rsp_ready(s_rsp_ready), .ovf_flags(w_ovf)
   );

   perf_memsys_collector #(.NUM_CHANNELS(2), .CTR_BITS(8), .INC_BITS(4), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .enable(s_enable), .evt_inc(s_inc),
      .clear(s_clear), .snap(s_snap), .req_valid(s_req_valid), .req_addr(s_req_addr),
      .req_ready(t_req_ready), .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data),
      .rsp_err(t_rsp_err), .rsp_ready(s_rsp_ready), .ovf_flags(t_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inc(input int ch, input int v);
      evt_inc[ch*IB +: IB] = IB'(v);
   endtask

   task automatic rd(input int a, input logic [CB-1:0] exp, input logic exp_err, input string tag);
      req_addr  = AB'(a);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk({tag, "_vld"}, 64'(rsp_valid), 64'(1));
      chk({tag, "_dat"}, 64'(rsp_data), 64'(exp));
      chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
   endtask

   initial begin
      logic [CB-1:0] e;
      #1 reset = 1'b0;
      #1;
      chk("rst_vld", 64'(rsp_valid), 64'(0));
      chk("rst_dat", 64'(rsp_data), 64'(0));
      chk("rst_err", 64'(rsp_err), 64'(0));
      chk("rst_ovf", 64'(ovf_flags), 64'(0));
      chk("rst_rdy", 64'(req_ready), 64'(1));
      tick();
      tick();
      reset  = 1'b1;
      enable = 1'b1;

      // basic count: 10 x 5 on channel 3
      set_inc(3, 5);
      repeat (10) tick();
      set_inc(3, 0);
      snap = 1'b1; tick(); snap = 1'b0;
      rd(3, 50, 1'b0, "c3");
      rd(0, 0, 1'b0, "c0");
      rd(25, 0, 1'b0, "c25");

      // read-and-reset with a same-cycle increment
      set_inc(1, 10);
      repeat (10) tick();
      set_inc(1, 7);
      snap = 1'b1; clear = 1'b1;
      tick();
      snap = 1'b0; clear = 1'b0;
      tick();
      set_inc(1, 0);
      rd(1, 100, 1'b0, "rr_c1");
      rd(3, 50, 1'b0, "rr_c3");
      chk("rr_ovf", 64'(ovf_flags), 64'(0));
      snap = 1'b1; tick(); snap = 1'b0;
      rd(1, 7, 1'b0, "post_c1");
      rd(3, 0, 1'b0, "post_c3");
      tick();
      chk("drain_vld", 64'(rsp_valid), 64'(0));

      // out-of-range read, then stall with a new request offered
      rsp_ready = 1'b0;
      req_addr  = AB'(26);
      req_valid = 1'b1;
      tick();
      chk("oor_vld", 64'(rsp_valid), 64'(1));
      chk("oor_err", 64'(rsp_err), 64'(1));
      chk("oor_dat", 64'(rsp_data), 64'(0));
      req_addr = AB'(1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_vld", 64'(rsp_valid), 64'(1));
         chk("stall_err", 64'(rsp_err), 64'(1));
         chk("stall_dat", 64'(rsp_data), 64'(0));
         chk("stall_rdy", 64'(req_ready), 64'(0));
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      chk("stall_drop", 64'(rsp_valid), 64'(0));

      // streaming reads with a snap in the middle
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < NCH; i++) set_inc(i, (i % 15) + 1);
      repeat (2) tick();
      snap = 1'b1; tick(); snap = 1'b0;
      evt_inc = '0;
      for (int k = 0; k < NCH; k++) begin
         req_addr  = AB'(k);
         req_valid = 1'b1;
         snap      = (k == 10);
         tick();
         e = CB'(((k <= 10) ? 2 : 3) * ((k % 15) + 1));
         chk("strm_vld", 64'(rsp_valid), 64'(1));
         chk($sformatf("strm_dat%0d", k), 64'(rsp_data), 64'(e));
      end
      req_valid = 1'b0;
      snap      = 1'b0;
      tick();
      chk("strm_end", 64'(rsp_valid), 64'(0));

      // small builds: wrap vs saturate at 8 bits
      s_enable = 1'b1;
      s_inc[3:0] = 4'd15;
      repeat (17) tick();
      chk("w_ovf_pre", 64'(w_ovf), 64'(0));
      chk("t_ovf_pre", 64'(t_ovf), 64'(0));
      s_inc[3:0] = 4'd2;
      tick();
      s_inc = '0;
      chk("w_ovf", 64'(w_ovf), 64'(1));
      chk("t_ovf", 64'(t_ovf), 64'(1));
      s_snap = 1'b1; tick(); s_snap = 1'b0;
      chk("w_rdy", 64'(w_req_ready), 64'(1));
      chk("t_rdy", 64'(t_req_ready), 64'(1));
      s_req_addr  = 1'b0;
      s_req_valid = 1'b1;
      tick();
      s_req_valid = 1'b0;
      chk("w_vld", 64'(w_rsp_valid), 64'(1));
      chk("w_dat", 64'(w_rsp_data), 64'(1));
      chk("w_err", 64'(w_rsp_err), 64'(0));
      chk("t_vld", 64'(t_rsp_valid), 64'(1));
      chk("t_dat", 64'(t_rsp_data), 64'(255));
      chk("t_err", 64'(t_rsp_err), 64'(0));
      s_clear = 1'b1;
      s_inc[3:0] = 4'd2;
      tick();
      s_clear = 1'b0;
      s_inc   = '0;
      chk("w_ovf_clr", 64'(w_ovf), 64'(0));
      chk("t_ovf_clr", 64'(t_ovf), 64'(0));
      s_snap = 1'b1; tick(); s_snap = 1'b0;
      s_req_valid = 1'b1;
      tick();
      s_req_valid = 1'b0;
      chk("w_dat_clr", 64'(w_rsp_data), 64'(0));
      chk("t_dat_clr", 64'(t_rsp_data), 64'(0));

      // asynchronous reset while counting and holding a response
      set_inc(3, 1);
      rsp_ready = 1'b0;
      req_addr  = AB'(5);
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("pre_rst_vld", 64'(rsp_valid), 64'(1));
      chk("pre_rst_dat", 64'(rsp_data), 64'(18));
      #3 reset = 1'b0;
      #1;
      chk("arst_vld", 64'(rsp_valid), 64'(0));
      chk("arst_dat", 64'(rsp_data), 64'(0));
      chk("arst_err", 64'(rsp_err), 64'(0));
      chk("arst_ovf", 64'(ovf_flags), 64'(0));
      @(posedge clk);
      #1;
      reset     = 1'b1;
      rsp_ready = 1'b1;
      repeat (4) tick();
      set_inc(3, 0);
      snap = 1'b1; tick(); snap = 1'b0;
      rd(3, 4, 1'b0, "rst_c3");
      rd(5, 0, 1'b0, "rst_c5");
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/perf_memsys_collector.md
Name: perf_memsys_collector

Overview:
- Parametrised accumulator for memory-system performance events: the next generation of the fixed-field memsys perf bundle.
- Takes NUM_CHANNELS per-cycle increment inputs from cache, shared-memory and memory-side sources and holds one CTR_BITS live counter per channel.
- Adds wrap or saturate mode, sticky overflow flags, atomic snapshot and global clear.
- Exposes a ready/valid read port so CSR or host logic reads snapshot values one channel at a time.

Parameters:
- NUM_CHANNELS, 26: number of counted event channels.
- CTR_BITS, 44: width of each live and snapshot counter.
- INC_BITS, 4: width of each per-cycle increment. Max increment per cycle is 2^INC_BITS-1.
- SATURATE, 0: 0 = counters wrap modulo 2^CTR_BITS; 1 = counters clamp at all-ones.
- ADDR_BITS, $clog2(NUM_CHANNELS): read address width (derived).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset.
- enable, in, 1: global count enable. Increments are ignored when low.
- evt_inc, in, NUM_CHANNELS*INC_BITS: per-channel increment. Channel i occupies bits [i*INC_BITS +: INC_BITS].
- clear, in, 1: zero all live counters and overflow flags.
- snap, in, 1: copy all live counters into the snapshot bank.
- req_valid, in, 1: read request valid.
- req_addr, in, ADDR_BITS: channel index to read.
- req_ready, out, 1: read request accepted.
- rsp_valid, out, 1: read response valid.
- rsp_data, out, CTR_BITS: snapshot value of the requested channel.
- rsp_err, out, 1: request address was >= NUM_CHANNELS.
- rsp_ready, in, 1: response consumer ready.
- ovf_flags, out, NUM_CHANNELS: sticky per-channel overflow flags, taken from live counters.

Behaviour:

Reset (asynchronous assert, synchronous deassertion handled upstream):
- Live counters, snapshot bank and ovf_flags are 0.
- rsp_valid = 0, rsp_data = 0, rsp_err = 0.
- An in-flight response is dropped. No request is remembered across reset.

Counting, per channel i, every cycle:
- sum = live[i] + evt_inc[i], zero-extended, CTR_BITS+1 bits. Applied only when enable=1 and clear=0.
- SATURATE=0: live[i] <= sum[CTR_BITS-1:0]. If the carry bit is 1, set ovf_flags[i].
- SATURATE=1: if the carry bit is 1, live[i] <= all-ones and ovf_flags[i] is set; otherwise live[i] <= sum.
- evt_inc[i]=0 leaves the counter unchanged. The flag is never set by a zero increment.

Clear:
- clear=1: live counters <= 0 and ovf_flags <= 0 next cycle.
- Same-cycle increments are discarded: clear wins over increment.
- The snapshot bank is not affected by clear.

Snapshot:
- snap=1: the snapshot bank <= live values as of the start of the cycle (pre-increment, pre-clear).
- All channels are captured in the same cycle (atomic).
- snap with clear in the same cycle: the snapshot holds the old values and the live counters go to 0. This is the read-and-reset idiom.

Read port:
- Single-entry output register.
- req_ready = !rsp_valid || rsp_ready.
- Handshake on req_valid && req_ready. Next cycle: rsp_valid=1, rsp_data = snapshot[req_addr] sampled at the handshake cycle, rsp_err=0.
- Out-of-range req_addr: rsp_data=0, rsp_err=1.
- snap in the same cycle as a request handshake: the response returns the pre-snap snapshot value.
- rsp_valid stays high and rsp_data/rsp_err are held stable until rsp_ready=1.
- Back-to-back reads: with rsp_ready held high, one response per cycle, latency 1.
- rsp_valid && rsp_ready with no new request: rsp_valid <= 0.

ovf_flags:
- Registered, updated one cycle after the overflowing increment.

Test Plan:
- Reset, then enable=1, channel 3 inc=5 for 10 cycles, snap, read addr 3 -> rsp_valid next cycle, rsp_data=50, rsp_err=0. Other channels read 0.
- SATURATE=0, CTR_BITS=8: channel 0 preset near top by driving inc=15 for 17 cycles (255), then inc=2 -> live=1, ovf_flags[0]=1. SATURATE=1, same stimulus -> live=255, ovf_flags[0]=1.
- Channel 1 holds 100, then snap=1 and clear=1 in the same cycle together with inc=7 -> snapshot[1]=100, live[1]=0, ovf cleared. Next cycle inc=7 -> live 7.
- Read addr=NUM_CHANNELS (26) -> rsp_err=1, rsp_data=0. Hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_err stay stable, req_ready=0. A request offered during the stall is not accepted.
- Streaming reads of addrs 0..25 with rsp_ready=1 -> 26 responses on 26 consecutive cycles, each equal to its snapshot value. A snap mid-stream affects only requests handshaken after the snap cycle.
- Assert reset low mid-count and with rsp_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, counting restarts from 0.
